// File: rtl/count_tracker.sv
// Monitor for a 4-bit up/down counter. It checks every sampled step against the
// selected direction, extends the count with a wrap epoch, and queues wrap/error events.
module count_tracker #(
   parameter int unsigned EPOCH_W    = 8,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [3:0]         count_in,
   input  logic               updown,
   output logic [EPOCH_W+3:0] ext_count,
   output logic               step_err,
   output logic [3:0]         err_cnt,
   output logic               evt_valid,
   output logic [5:0]         evt_data,
   input  logic               evt_ready,
   output logic               evt_ovf
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]   FullCnt  = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0]   CntOne   = CNT_W'(1);
   localparam logic [PTR_W-1:0]   PtrOne   = PTR_W'(1);
   localparam logic [EPOCH_W-1:0] EpochOne = EPOCH_W'(1);
   localparam logic [1:0]         EvtUp      = 2'b01;
   localparam logic [1:0]         EvtDown    = 2'b10;
   localparam logic [1:0]         EvtIllegal = 2'b11;

   typedef enum logic {StUnprimed, StPrimed} state_e;

   state_e             state_q, state_d;
   logic [3:0]         last_sample_q, last_sample_d;
   logic [EPOCH_W-1:0] epoch_q, epoch_d;
   logic [3:0]         err_cnt_q, err_cnt_d;
   logic               step_err_q, step_err_d;
   logic               ovf_q, ovf_d;
   logic               evt_valid_q, evt_valid_d;
   logic [5:0]         mem_q [FIFO_DEPTH];
   logic [5:0]         mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;

   logic       push, pop, full, do_push;
   logic [5:0] push_data;
   logic [3:0] delta;

   // Step classification and tracking state.
   always_comb begin
      state_d       = state_q;
      last_sample_d = last_sample_q;
      epoch_d       = epoch_q;
      err_cnt_d     = err_cnt_q;
      step_err_d    = 1'b0;
      push          = 1'b0;
      push_data     = '0;
      delta         = count_in - last_sample_q;
      if (en) begin
         last_sample_d = count_in;
         unique case (state_q)
            StUnprimed: state_d = StPrimed;
            StPrimed: begin
               if (delta != 4'd0) begin
                  if (!updown && delta == 4'd1) begin
                     if (last_sample_q == 4'hF) begin
                        epoch_d   = epoch_q + EpochOne;
                        push      = 1'b1;
                        push_data = {EvtUp, count_in};
                     end
                  end else if (updown && delta == 4'hF) begin
                     if (last_sample_q == 4'h0) begin
                        epoch_d   = epoch_q - EpochOne;
                        push      = 1'b1;
                        push_data = {EvtDown, count_in};
                     end
                  end else begin
                     step_err_d = 1'b1;
                     if (err_cnt_q != 4'hF) err_cnt_d = err_cnt_q + 4'd1;
                     push      = 1'b1;
                     push_data = {EvtIllegal, count_in};
                  end
               end
            end
            default: state_d = StUnprimed;
         endcase
      end
   end

   // Event FIFO; a push into a full FIFO only survives if a pop frees the slot.
   always_comb begin
      pop      = evt_valid_q && evt_ready;
      full     = (fifo_cnt_q == FullCnt);
      do_push  = push && (!full || pop);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PtrOne;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PtrOne;
      fifo_cnt_d = fifo_cnt_q;
      if (do_push && !pop) fifo_cnt_d = fifo_cnt_q + CntOne;
      else if (!do_push && pop) fifo_cnt_d = fifo_cnt_q - CntOne;
      ovf_d       = ovf_q | (push & full & ~pop);
      evt_valid_d = (fifo_cnt_d != '0);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= StUnprimed;
         last_sample_q <= '0;
         epoch_q       <= '0;
         err_cnt_q     <= '0;
         step_err_q    <= 1'b0;
         ovf_q         <= 1'b0;
         evt_valid_q   <= 1'b0;
         mem_q         <= '{default: '0};
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         fifo_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         last_sample_q <= last_sample_d;
         epoch_q       <= epoch_d;
         err_cnt_q     <= err_cnt_d;
         step_err_q    <= step_err_d;
         ovf_q         <= ovf_d;
         evt_valid_q   <= evt_valid_d;
         mem_q         <= mem_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         fifo_cnt_q    <= fifo_cnt_d;
      end
   end

   assign ext_count = {epoch_q, last_sample_q};
   assign step_err  = step_err_q;
   assign err_cnt   = err_cnt_q;
   assign evt_valid = evt_valid_q;
   assign evt_data  = mem_q[rd_ptr_q];
   assign evt_ovf   = ovf_q;

endmodule

// File: tb/tb_count_tracker.sv
// Bench for count_tracker: directed scenarios then random traffic, all checked
// against an arithmetic model of the tracker and a queue model of the event FIFO.
module tb_count_tracker;

   localparam int unsigned EPOCH_W    = 8;
   localparam int unsigned FIFO_DEPTH = 4;

   logic                clk = 1'b0;
   logic                rst, en, updown, evt_ready;
   logic [3:0]          count_in;
   logic [EPOCH_W+3:0]  ext_count;
   logic                step_err, evt_valid, evt_ovf;
   logic [3:0]          err_cnt;
   logic [5:0]          evt_data;

   int checks = 0;
   int errors = 0;

   // Reference model state
   bit         m_primed;
   int         m_last, m_epoch, m_err;
   bit         m_step_err, m_ovf;
   logic [5:0] m_q[$];

   count_tracker #(.EPOCH_W(EPOCH_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .count_in  (count_in),
      .updown    (updown),
      .ext_count (ext_count),
      .step_err  (step_err),
      .err_cnt   (err_cnt),
      .evt_valid (evt_valid),
      .evt_data  (evt_data),
      .evt_ready (evt_ready),
      .evt_ovf   (evt_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      int  delta;
      bit  pushed, pop, full;
      logic [5:0] ev;
      if (!rst) begin
         m_primed = 0; m_last = 0; m_epoch = 0; m_err = 0;
         m_step_err = 0; m_ovf = 0; m_q.delete();
         return;
      end
      m_step_err = 0;
      pushed     = 0;
      ev         = '0;
      if (en) begin
         if (!m_primed) begin
            m_primed = 1;
         end else begin
            delta = (int'(count_in) - m_last + 16) % 16;
            if (delta == 0) begin
            end else if (!updown && delta == 1) begin
               if (m_last == 15) begin
                  m_epoch = (m_epoch + 1) % 256;
                  pushed  = 1;
                  ev      = {2'b01, count_in};
               end
            end else if (updown && delta == 15) begin
               if (m_last == 0) begin
                  m_epoch = (m_epoch + 255) % 256;
                  pushed  = 1;
                  ev      = {2'b10, count_in};
               end
            end else begin
               m_step_err = 1;
               if (m_err < 15) m_err++;
               pushed = 1;
               ev     = {2'b11, count_in};
            end
         end
         m_last = int'(count_in);
      end
      pop  = (m_q.size() > 0) && evt_ready;
      full = (m_q.size() == FIFO_DEPTH);
      if (pop) void'(m_q.pop_front());
      if (pushed) begin
         if (full && !pop) m_ovf = 1;
         else m_q.push_back(ev);
      end
   endtask

   // Apply inputs, advance one edge, update model, compare every output.
   task automatic drive(input logic r, input logic e, input int c, input logic ud,
                        input logic rdy);
      rst = r; en = e; count_in = 4'(c); updown = ud; evt_ready = rdy;
      @(posedge clk);
      model_edge();
      #1;
      chk("ext_count", 32'(ext_count), 32'(m_epoch * 16 + m_last));
      chk("step_err", 32'(step_err), 32'(m_step_err));
      chk("err_cnt", 32'(err_cnt), 32'(m_err));
      chk("evt_valid", 32'(evt_valid), 32'(m_q.size() > 0));
      chk("evt_ovf", 32'(evt_ovf), 32'(m_ovf));
      if (m_q.size() > 0) chk("evt_data", 32'(evt_data), 32'(m_q[0]));
   endtask

   initial begin
      int c, r;
      drive(0, 0, 0, 0, 0);
      drive(0, 1, 3, 0, 1);
      chk("rst_ext", 32'(ext_count), 32'h0);
      chk("rst_valid", 32'(evt_valid), 32'h0);

      // 18 up steps through one wrap
      for (int i = 0; i < 18; i++) drive(1, 1, i % 16, 0, 0);
      chk("up18_ext", 32'(ext_count), 32'h011);
      chk("up18_evt", 32'(evt_data), 32'h10);

      // Down wrap
      drive(0, 0, 0, 0, 0);
      drive(1, 1, 0, 1, 0);
      drive(1, 1, 15, 1, 0);
      chk("dn_ext", 32'(ext_count), 32'hFFF);
      chk("dn_evt", 32'(evt_data), 32'h2F);

      // Illegal step then saturation
      drive(0, 0, 0, 0, 0);
      drive(1, 1, 3, 0, 0);
      drive(1, 1, 7, 0, 0);
      chk("ill_err", 32'(step_err), 32'h1);
      chk("ill_evt", 32'(evt_data), 32'h37);
      drive(1, 1, 7, 0, 0);
      chk("ill_pulse", 32'(step_err), 32'h0);
      for (int i = 0; i < 20; i++) drive(1, 1, (m_last + 5) % 16, 0, 1);
      chk("ill_sat", 32'(err_cnt), 32'hF);

      // Overflow with backpressure, then push+pop while full, then drain
      drive(0, 0, 0, 0, 0);
      drive(1, 1, 0, 0, 0);
      for (int i = 1; i <= 5; i++) drive(1, 1, (i * 5) % 16, 0, 0);
      chk("ovf_flag", 32'(evt_ovf), 32'h1);
      chk("ovf_head", 32'(evt_data), 32'h35);
      drive(1, 1, 14, 0, 1);
      for (int i = 0; i < 5; i++) drive(1, 0, 14, 0, 1);
      chk("ovf_sticky", 32'(evt_ovf), 32'h1);

      // Enable gating and hold
      drive(0, 0, 0, 0, 0);
      drive(1, 1, 5, 0, 1);
      drive(1, 0, 9, 0, 1);
      drive(1, 0, 9, 1, 1);
      drive(1, 1, 6, 0, 1);
      chk("gate_err", 32'(err_cnt), 32'h0);
      drive(1, 1, 6, 0, 1);
      chk("hold_valid", 32'(evt_valid), 32'h0);

      // Mid-operation reset with 3 events queued and epoch 2
      drive(0, 0, 0, 0, 0);
      for (int i = 0; i < 19; i++) drive(1, 1, (14 + i) % 16, 0, 0);
      drive(1, 1, 5, 0, 0);
      chk("mid_ext", 32'(ext_count), 32'h025);
      drive(0, 1, 9, 0, 0);
      chk("mid_valid", 32'(evt_valid), 32'h0);
      chk("mid_ext0", 32'(ext_count), 32'h0);
      chk("mid_err0", 32'(err_cnt), 32'h0);
      chk("mid_ovf0", 32'(evt_ovf), 32'h0);
      drive(1, 1, 9, 0, 0);
      chk("reprime_valid", 32'(evt_valid), 32'h0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 9);
         if (r < 4) c = (m_last + 1) % 16;
         else if (r < 7) c = (m_last + 15) % 16;
         else if (r == 7) c = m_last;
         else c = $urandom_range(0, 15);
         drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) != 0), c,
               (r < 4) ? 1'b0 : (r < 7) ? 1'b1 : 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
